lab_hold_scheduler: RTL and testbench
=====================================

LAB_HOLD_SCHEDULER -- requirements
Module: lab_hold_scheduler

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16'd50000, digitize watchdog limit in clk_i cycles (used only with DIGITIZE_TIMEOUT_EN).
REQ-002 Port: clk_i  in  1  33 MHz system clock; the only clock.
REQ-003 Port: rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-004 Port: hold_i  in  4  TURF HOLD per LAB buffer, already synchronous to clk_i, level.
REQ-005 Port: done_i  in  1  one-cycle pulse from LAB readout: current digitization complete.
REQ-006 Port: release_i  in  4  one-cycle pulses from register interface: buffer k read out.
REQ-007 Port: digitize_o  out  4  one-hot, one-cycle digitize request to LAB readout.
REQ-008 Port: ready_o  out  4  buffer k digitized and readable.
REQ-009 Port: busy_o  out  1  no buffer EMPTY.
REQ-010 Port: dropped_o  out  8  saturating count of ignored HOLD edges.
REQ-011 Port: error_o  out  1  sticky watchdog error.

Function
REQ-012 Each buffer SHALL hold a state: EMPTY, HELD, DIGITIZING, READY.
REQ-013 A hold_i[k] rising edge (registered previous value vs. current) SHALL move EMPTY buffer k to HELD on the next edge.
REQ-014 A rising edge on a non-EMPTY buffer SHALL be ignored and increment dropped_o, saturating at 8'hFF.
REQ-015 Scheduler FSM states: IDLE, ISSUE, WAIT_DONE.
REQ-016 IDLE: if any buffer HELD, select one round-robin, starting from the index after the last serviced buffer (initially 0), go to ISSUE.
REQ-017 ISSUE: assert digitize_o[sel] for exactly one cycle, set buffer sel DIGITIZING, go to WAIT_DONE.
REQ-018 WAIT_DONE: on done_i, set buffer sel READY, go to IDLE; done_i in IDLE or ISSUE SHALL be ignored.
REQ-019 At most one buffer SHALL be DIGITIZING at any time.
REQ-020 release_i[k] on READY buffer k SHALL set it EMPTY next edge; release on any other state SHALL be ignored.
REQ-021 Same-cycle hold edge and release on READY buffer k: release wins, buffer EMPTY, hold counted dropped.
REQ-022 ready_o[k] = (state k == READY); busy_o = no buffer EMPTY; both registered-state decodes, no input combinational paths.
REQ-023 Minimum HOLD-to-digitize latency: edge at cycle n, HELD at n+1, IDLE selects at n+1, digitize_o high at n+2.

Reset
REQ-024 rst_n_i low SHALL asynchronously force all buffers EMPTY, FSM IDLE, round-robin pointer 0, digitize_o 0, dropped_o 0, error_o 0, edge registers 0.
REQ-025 Reset mid-digitization SHALL abandon the operation; a later stray done_i SHALL be ignored.

Configuration
REQ-026 Macro DIGITIZE_TIMEOUT_EN defined: a 16-bit counter clears on ISSUE, counts in WAIT_DONE; reaching TIMEOUT_CYCLES SHALL set buffer sel EMPTY, set error_o, return to IDLE.
REQ-027 Macro DIGITIZE_TIMEOUT_EN undefined: no counter, WAIT_DONE waits indefinitely, error_o tied 0.

Structure
REQ-028 Buffer-state and FSM-state encodings and NBUF=4 SHALL live in shared package lab_sched_pkg.
REQ-029 Sub-module rr_arbiter4 (4-request round-robin, pointer input, one-hot grant output) SHALL be instantiated once.

Verification
REQ-030 hold_i 0000->0001 at cycle 10 -> digitize_o=0001 at cycle 12; done_i at 40 -> ready_o=0001 at 41; release_i=0001 -> ready_o=0000.
REQ-031 hold_i 0000->1111 in one cycle -> digitize_o sequence 0001,0010,0100,1000, each after prior done_i; busy_o=1 throughout.
REQ-032 All buffers READY, 300 further hold edges -> dropped_o=8'hFF, no digitize_o.
REQ-033 Same-cycle release_i[2] and hold_i[2] edge on READY buffer 2 -> buffer 2 EMPTY, dropped_o +1.
REQ-034 With DIGITIZE_TIMEOUT_EN, TIMEOUT_CYCLES=100, no done_i -> buffer EMPTY and error_o=1 exactly 100 cycles after ISSUE; without macro, error_o stays 0.
REQ-035 rst_n_i low during WAIT_DONE, done_i after release of reset -> all outputs 0, no buffer READY.

Source files
------------

// File: rtl/lab_sched_pkg.sv
// Shared types and helpers for the LAB hold scheduler.
// Holds the buffer-state and scheduler-state encodings and the buffer count.
package lab_sched_pkg;

  localparam int NBUF = 4;

  // Life cycle of one LAB buffer.
  typedef enum logic [1:0] {
    BUF_EMPTY      = 2'd0,
    BUF_HELD       = 2'd1,
    BUF_DIGITIZING = 2'd2,
    BUF_READY      = 2'd3
  } buf_state_e;

  // Scheduler that feeds the single LAB readout engine.
  typedef enum logic [1:0] {
    SCH_IDLE      = 2'd0,
    SCH_ISSUE     = 2'd1,
    SCH_WAIT_DONE = 2'd2
  } sched_state_e;

  // Index of the set bit of a one-hot vector (0 when no bit is set).
  function automatic logic [1:0] onehot_to_idx(input logic [NBUF-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NBUF; i++) begin
      if (oh[i]) idx = i[1:0];
    end
    return idx;
  endfunction

  // Number of set bits, used to add several dropped edges in one cycle.
  function automatic logic [2:0] count_ones(input logic [NBUF-1:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < NBUF; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-request round-robin arbiter.
// Searches upward from ptr_i (wrapping) and grants the first active request.
module rr_arbiter4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [3:0] grant_o
);

  logic [1:0] idx;

  // Walk candidates from farthest to nearest so the nearest to ptr_i wins.
  always_comb begin
    grant_o = 4'b0000;
    idx     = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_i + i[1:0];
      if (req_i[idx]) grant_o = 4'b0001 << idx;
    end
  end

endmodule

// File: rtl/lab_hold_scheduler.sv
// LAB hold scheduler: tracks four LAB buffers from TURF HOLD through
// digitization to readout, and feeds one digitize request at a time to the
// shared LAB readout engine in round-robin order.
// Optional feature macro: DIGITIZE_TIMEOUT_EN (digitize watchdog).
module lab_hold_scheduler
  import lab_sched_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [3:0] hold_i,
  input  logic       done_i,
  input  logic [3:0] release_i,
  output logic [3:0] digitize_o,
  output logic [3:0] ready_o,
  output logic       busy_o,
  output logic [7:0] dropped_o,
  output logic       error_o
);

  logic [NBUF-1:0] hold_q;
  logic [NBUF-1:0] rise;
  buf_state_e      buf_q [NBUF];
  buf_state_e      buf_d [NBUF];
  logic [NBUF-1:0] held_vec;
  logic [NBUF-1:0] ready_vec;
  logic [NBUF-1:0] empty_vec;
  logic [NBUF-1:0] drop_vec;

  sched_state_e    sched_q;
  logic [1:0]      sel_q;
  logic [NBUF-1:0] sel_oh;
  logic [1:0]      ptr_q;
  logic [NBUF-1:0] digitize_q;
  logic [NBUF-1:0] grant;
  logic [1:0]      grant_idx;
  logic [7:0]      dropped_q;
  logic [7:0]      dropped_d;
  logic [8:0]      dropped_sum;

  logic            issue_fire;
  logic            done_fire;
  logic            timeout_fire;

  assign rise       = hold_i & ~hold_q;
  assign sel_oh     = 4'b0001 << sel_q;
  assign issue_fire = (sched_q == SCH_ISSUE);
  assign done_fire  = (sched_q == SCH_WAIT_DONE) && done_i;

  // Per-buffer state decodes feeding the arbiter, outputs and drop counter.
  for (genvar gi = 0; gi < NBUF; gi++) begin : g_decode
    assign held_vec[gi]  = (buf_q[gi] == BUF_HELD);
    assign ready_vec[gi] = (buf_q[gi] == BUF_READY);
    assign empty_vec[gi] = (buf_q[gi] == BUF_EMPTY);
    // A non-EMPTY buffer cannot take a new hold, including one being
    // released this very cycle.
    assign drop_vec[gi]  = rise[gi] && (buf_q[gi] != BUF_EMPTY);
  end

  rr_arbiter4 u_arb (
    .req_i   (held_vec),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  assign grant_idx = onehot_to_idx(grant);

`ifdef DIGITIZE_TIMEOUT_EN
  logic [15:0] wd_cnt_q;
  logic        error_q;

  // wd_cnt_q reads 0 in the first WAIT_DONE cycle, so matching TIMEOUT-2
  // drops the buffer on the edge that ends the TIMEOUT-th cycle after ISSUE.
  assign timeout_fire = (sched_q == SCH_WAIT_DONE) && !done_i &&
                        (wd_cnt_q == TIMEOUT_CYCLES - 16'd2);
  assign error_o      = error_q;
`else
  assign timeout_fire = 1'b0;
  assign error_o      = 1'b0;
`endif

  // Previous HOLD level for rising-edge detection.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) hold_q <= '0;
    else          hold_q <= hold_i;
  end

  // Buffer next-state: holds fill EMPTY buffers, the scheduler moves the
  // selected buffer, and release only drains READY buffers.
  always_comb begin
    for (int k = 0; k < NBUF; k++) begin
      buf_d[k] = buf_q[k];
      case (buf_q[k])
        BUF_EMPTY:      if (rise[k]) buf_d[k] = BUF_HELD;
        BUF_HELD:       if (issue_fire && sel_oh[k]) buf_d[k] = BUF_DIGITIZING;
        BUF_DIGITIZING: begin
          if (done_fire && sel_oh[k])         buf_d[k] = BUF_READY;
          else if (timeout_fire && sel_oh[k]) buf_d[k] = BUF_EMPTY;
        end
        BUF_READY:      if (release_i[k]) buf_d[k] = BUF_EMPTY;
        default:        buf_d[k] = BUF_EMPTY;
      endcase
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < NBUF; k++) buf_q[k] <= BUF_EMPTY;
    end else begin
      for (int k = 0; k < NBUF; k++) buf_q[k] <= buf_d[k];
    end
  end

  // Scheduler FSM with registered one-cycle digitize request.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sched_q    <= SCH_IDLE;
      sel_q      <= 2'd0;
      ptr_q      <= 2'd0;
      digitize_q <= '0;
`ifdef DIGITIZE_TIMEOUT_EN
      wd_cnt_q   <= 16'd0;
      error_q    <= 1'b0;
`endif
    end else begin
      digitize_q <= '0;
      case (sched_q)
        SCH_IDLE: begin
          if (|held_vec) begin
            sel_q      <= grant_idx;
            ptr_q      <= grant_idx + 2'd1;
            digitize_q <= grant;
            sched_q    <= SCH_ISSUE;
          end
        end
        SCH_ISSUE: begin
          sched_q  <= SCH_WAIT_DONE;
`ifdef DIGITIZE_TIMEOUT_EN
          wd_cnt_q <= 16'd0;
`endif
        end
        SCH_WAIT_DONE: begin
          if (done_i) begin
            sched_q <= SCH_IDLE;
          end
`ifdef DIGITIZE_TIMEOUT_EN
          else if (timeout_fire) begin
            sched_q <= SCH_IDLE;
            error_q <= 1'b1;
          end else begin
            wd_cnt_q <= wd_cnt_q + 16'd1;
          end
`endif
        end
        default: sched_q <= SCH_IDLE;
      endcase
    end
  end

  // Saturating sum of ignored hold edges; several may land in one cycle.
  assign dropped_sum = {1'b0, dropped_q} + {6'd0, count_ones(drop_vec)};
  assign dropped_d   = dropped_sum[8] ? 8'hFF : dropped_sum[7:0];

  // Dropped-edge counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) dropped_q <= 8'd0;
    else          dropped_q <= dropped_d;
  end

  assign digitize_o = digitize_q;
  assign ready_o    = ready_vec;
  assign busy_o     = ~|empty_vec;
  assign dropped_o  = dropped_q;

endmodule

// File: tb/tb_lab_hold_scheduler.sv
// Directed self-checking bench for lab_hold_scheduler.
// Honours DIGITIZE_TIMEOUT_EN for the watchdog scenario.
module tb_lab_hold_scheduler;

  logic       clk;
  logic       rst_n;
  logic [3:0] hold;
  logic       done;
  logic [3:0] rel;
  logic [3:0] digitize;
  logic [3:0] ready;
  logic       busy;
  logic [7:0] dropped;
  logic       error;

  int n_checks = 0;
  int n_pass   = 0;

  lab_hold_scheduler #(.TIMEOUT_CYCLES(16'd100)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .hold_i     (hold),
    .done_i     (done),
    .release_i  (rel),
    .digitize_o (digitize),
    .ready_o    (ready),
    .busy_o     (busy),
    .dropped_o  (dropped),
    .error_o    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) begin
      n_pass++;
      $display("ok   %s obs=%0h", tag, obs);
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hold  = 4'b0000;
    done  = 1'b0;
    rel   = 4'b0000;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic pulse_done();
    done = 1'b1;
    step();
    done = 1'b0;
  endtask

  // Step until digitize is seen or the bound runs out.
  task automatic wait_digitize(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (digitize != 4'b0000) break;
      step();
    end
  endtask

  logic saw_dig;

  initial begin
    rst_n = 1'b0;
    hold  = 4'b0000;
    done  = 1'b0;
    rel   = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_digitize", {28'd0, digitize}, 32'h0);
    check("rst_ready",    {28'd0, ready},    32'h0);
    check("rst_busy",     {31'd0, busy},     32'h0);
    check("rst_dropped",  {24'd0, dropped},  32'h0);
    check("rst_error",    {31'd0, error},    32'h0);
    rst_n = 1'b1;
    step();

    // Single hold: two-edge latency, one-cycle request, done -> READY.
    hold = 4'b0001;
    step();
    check("s1_no_dig_yet", {28'd0, digitize}, 32'h0);
    step();
    check("s1_dig",        {28'd0, digitize}, 32'h1);
    check("s1_busy",       {31'd0, busy},     32'h0);
    step();
    check("s1_dig_1cyc",   {28'd0, digitize}, 32'h0);
    rel = 4'b0001;            // release while DIGITIZING is ignored
    step();
    rel = 4'b0000;
    step();
    check("s1_not_ready",  {28'd0, ready},    32'h0);
    pulse_done();
    check("s1_ready",      {28'd0, ready},    32'h1);
    pulse_done();             // stray done in IDLE
    step();
    check("s1_stray_done", {28'd0, ready},    32'h1);
    check("s1_stray_dig",  {28'd0, digitize}, 32'h0);
    rel = 4'b0001;
    step();
    rel = 4'b0000;
    check("s1_released",   {28'd0, ready},    32'h0);
    hold = 4'b0000;
    step();

    // All four at once: round-robin from buffer 0, busy throughout.
    do_reset();
    hold = 4'b1111;
    step();
    check("s2_busy_held", {31'd0, busy},  32'h1);
    check("s2_ready0",    {28'd0, ready}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      wait_digitize(8);
      check($sformatf("s2_dig%0d", k), {28'd0, digitize}, 32'h1 << k);
      check($sformatf("s2_busy%0d", k), {31'd0, busy}, 32'h1);
      step();
      step();
      pulse_done();
      check($sformatf("s2_ready%0d", k), {28'd0, ready}, (32'h1 << (k + 1)) - 32'h1);
    end
    check("s2_all_busy", {31'd0, busy}, 32'h1);

    // All READY: 300 further edges are all dropped, counter saturates.
    saw_dig = 1'b0;
    for (int i = 0; i < 75; i++) begin
      hold = 4'b0000;
      step();
      if (digitize != 4'b0000) saw_dig = 1'b1;
      hold = 4'b1111;
      step();
      if (digitize != 4'b0000) saw_dig = 1'b1;
      if (i == 0) check("s3_drop_first", {24'd0, dropped}, 32'h4);
    end
    check("s3_drop_sat",  {24'd0, dropped}, 32'hFF);
    check("s3_no_dig",    {31'd0, saw_dig}, 32'h0);
    check("s3_ready_all", {28'd0, ready},   32'hF);

    // Release and new hold on READY buffer 2 in the same cycle.
    do_reset();
    hold = 4'b0100;
    step();
    wait_digitize(8);
    check("s4_dig2", {28'd0, digitize}, 32'h4);
    step();
    pulse_done();
    check("s4_ready2",   {28'd0, ready},   32'h4);
    check("s4_drop0",    {24'd0, dropped}, 32'h0);
    hold = 4'b0000;
    step();
    hold = 4'b0100;
    rel  = 4'b0100;
    step();
    rel  = 4'b0000;
    check("s4_rel_wins", {28'd0, ready},   32'h0);
    check("s4_drop1",    {24'd0, dropped}, 32'h1);
    check("s4_busy",     {31'd0, busy},    32'h0);
    saw_dig = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (digitize != 4'b0000) saw_dig = 1'b1;
    end
    check("s4_no_dig", {31'd0, saw_dig}, 32'h0);

    // Asynchronous reset during WAIT_DONE, stray done afterwards.
    hold = 4'b0000;
    step();
    hold = 4'b0001;
    step();
    wait_digitize(8);
    check("s5_dig", {28'd0, digitize}, 32'h1);
    step();
    #3;
    rst_n = 1'b0;
    hold  = 4'b0000;
    #1;
    check("s5_async_drop",  {24'd0, dropped}, 32'h0);
    check("s5_async_busy",  {31'd0, busy},    32'h0);
    step();
    rst_n = 1'b1;
    step();
    pulse_done();
    step();
    step();
    check("s5_ready",    {28'd0, ready},    32'h0);
    check("s5_busy",     {31'd0, busy},     32'h0);
    check("s5_digitize", {28'd0, digitize}, 32'h0);
    check("s5_error",    {31'd0, error},    32'h0);

    // Digitize with no done at all.
    hold = 4'b0001;
    step();
    wait_digitize(8);
    check("s6_dig", {28'd0, digitize}, 32'h1);
`ifdef DIGITIZE_TIMEOUT_EN
    repeat (99) step();
    check("s6_err_early", {31'd0, error}, 32'h0);
    step();
    check("s6_err_set",   {31'd0, error}, 32'h1);
    check("s6_empty",     {28'd0, ready}, 32'h0);
    pulse_done();
    step();
    check("s6_late_done", {28'd0, ready}, 32'h0);
`else
    repeat (150) step();
    check("s6_no_err",    {31'd0, error}, 32'h0);
    pulse_done();
    check("s6_ready",     {28'd0, ready}, 32'h1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
